// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef logic [15:0] word_t;

    localparam word_t RESET_PC  = 16'h0000;
    localparam word_t NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL
    } fetch_state_t;

    // Bring-up counters stick at all-ones instead of wrapping.
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port, IF/ID outputs.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  pcKeep;
    logic  ifKeep;
    logic  redirect;
    word_t redirectPc;
    logic  memUseInstr;
    word_t instrRdata;
    word_t instrAddr;
    logic  instrReq;
    word_t ifidInstr;
    word_t ifidPc;
    logic  ifidValid;
    word_t fetchCount;
    word_t bubbleCount;

    modport master (
        input  pcKeep, ifKeep, redirect, redirectPc, memUseInstr, instrRdata,
        output instrAddr, instrReq, ifidInstr, ifidPc, ifidValid, fetchCount, bubbleCount
    );

    modport slave (
        output pcKeep, ifKeep, redirect, redirectPc, memUseInstr, instrRdata,
        input  instrAddr, instrReq, ifidInstr, ifidPc, ifidValid, fetchCount, bubbleCount
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on keep, otherwise loads a bubble or a fetched word.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  keep,
    input  logic  bubble,
    input  word_t load_instr,
    input  word_t load_pc,
    output word_t instr,
    output word_t pc,
    output logic  valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (!keep) begin
            if (bubble) begin
                instr <= NOP_INSTR;
                pc    <= '0;
                valid <= 1'b0;
            end else begin
                instr <= load_instr;
                pc    <= load_pc;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, boot/run/stall control, IF/ID load and bring-up counters.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t state;
    word_t        pc;
    word_t        pc_seq;
    word_t        fetch_cnt;
    word_t        bubble_cnt;
    logic         take_bubble;
    word_t        ifid_instr;
    word_t        ifid_pc;
    logic         ifid_valid;

    assign pc_seq = pc + 16'd1;

    // Only a plain sequential fetch loads a real instruction; every other case is a bubble.
    always_comb begin
        take_bubble = 1'b1;
        if (state != BOOT && !bus.pcKeep && !bus.redirect && !bus.memUseInstr)
            take_bubble = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (state == BOOT) begin
                state <= RUN;
            end else if (bus.pcKeep) begin
                state <= bus.memUseInstr ? STALL : RUN;
            end else if (bus.redirect) begin
                pc    <= bus.redirectPc;
                state <= RUN;
            end else if (bus.memUseInstr) begin
                state <= STALL;
            end else begin
                pc    <= pc_seq;
                state <= RUN;
            end

            if (!bus.ifKeep) begin
                if (take_bubble)
                    bubble_cnt <= sat_inc(bubble_cnt);
                else
                    fetch_cnt <= sat_inc(fetch_cnt);
            end
        end
    end

    fetch_stage_if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .keep       (bus.ifKeep),
        .bubble     (take_bubble),
        .load_instr (bus.instrRdata),
        .load_pc    (pc_seq),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .valid      (ifid_valid)
    );

    assign bus.instrAddr   = pc;
    assign bus.instrReq    = (state != BOOT) && !bus.memUseInstr;
    assign bus.ifidInstr   = ifid_instr;
    assign bus.ifidPc      = ifid_pc;
    assign bus.ifidValid   = ifid_valid;
    assign bus.fetchCount  = fetch_cnt;
    assign bus.bubbleCount = bubble_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences, random run against a model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus();
    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    function automatic word_t mem_word(input word_t a);
        if (a == 16'h0000) return 16'hA001;
        if (a == 16'h0001) return 16'hA002;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    always_comb bus.instrRdata = mem_word(bus.instrAddr);

    // Behavioural reference state
    bit    m_booted;
    word_t m_pc, m_ii, m_ip, m_fc, m_bc;
    bit    m_iv;

    function automatic void m_reset();
        m_booted = 0; m_pc = 16'h0000; m_ii = 16'h0800; m_ip = 16'h0000;
        m_iv = 0; m_fc = 0; m_bc = 0;
    endfunction

    function automatic word_t sat(input word_t v);
        int n;
        n = int'(v) + 1;
        return (n > 65535) ? 16'hFFFF : word_t'(n);
    endfunction

    function automatic void m_edge(input bit pk, input bit ik, input bit rd,
                                   input word_t rpc, input bit mu);
        bit    bub;
        word_t w, nxt;
        w   = mem_word(m_pc);
        nxt = word_t'((int'(m_pc) + 1) % 65536);
        bub = 1;
        if (!m_booted) m_booted = 1;
        else if (pk) bub = 1;
        else if (rd) m_pc = rpc;
        else if (mu) bub = 1;
        else begin bub = 0; m_pc = nxt; end
        if (!ik) begin
            if (bub) begin m_ii = 16'h0800; m_ip = 0; m_iv = 0; m_bc = sat(m_bc); end
            else     begin m_ii = w; m_ip = nxt; m_iv = 1; m_fc = sat(m_fc); end
        end
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".addr"},  bus.instrAddr, m_pc);
        chk({tag, ".req"},   16'(bus.instrReq), 16'(m_booted && !bus.memUseInstr));
        chk({tag, ".valid"}, 16'(bus.ifidValid), 16'(m_iv));
        chk({tag, ".instr"}, bus.ifidInstr, m_ii);
        if (m_iv) chk({tag, ".ifpc"}, bus.ifidPc, m_ip);
        chk({tag, ".fcnt"},  bus.fetchCount, m_fc);
        chk({tag, ".bcnt"},  bus.bubbleCount, m_bc);
    endtask

    task automatic drive(input bit pk, input bit ik, input bit rd, input word_t rpc, input bit mu);
        bus.pcKeep = pk; bus.ifKeep = ik; bus.redirect = rd;
        bus.redirectPc = rpc; bus.memUseInstr = mu;
    endtask

    task automatic step(input bit pk, input bit ik, input bit rd, input word_t rpc, input bit mu);
        drive(pk, ik, rd, rpc, mu);
        @(posedge clk);
        m_edge(pk, ik, rd, rpc, mu);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".addr"},  bus.instrAddr, 16'h0000);
        chk({tag, ".req"},   16'(bus.instrReq), 16'h0000);
        chk({tag, ".valid"}, 16'(bus.ifidValid), 16'h0000);
        chk({tag, ".instr"}, bus.ifidInstr, 16'h0800);
        chk({tag, ".ifpc"},  bus.ifidPc, 16'h0000);
        chk({tag, ".fcnt"},  bus.fetchCount, 16'h0000);
        chk({tag, ".bcnt"},  bus.bubbleCount, 16'h0000);
    endtask

    typedef struct {
        bit    pk, ik;
        bit    e_valid;
        word_t e_instr, e_pc, e_addr, e_fc, e_bc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        word_t bc0, pc0;

        tbl[0] = '{0, 0, 0, 16'h0800,      16'h0000, 16'h0000, 16'd0, 16'd1};
        tbl[1] = '{0, 0, 1, 16'hA001,      16'h0001, 16'h0001, 16'd1, 16'd1};
        tbl[2] = '{0, 0, 1, 16'hA002,      16'h0002, 16'h0002, 16'd2, 16'd1};
        tbl[3] = '{0, 0, 1, mem_word(16'd2), 16'h0003, 16'h0003, 16'd3, 16'd1};
        tbl[4] = '{0, 0, 1, mem_word(16'd3), 16'h0004, 16'h0004, 16'd4, 16'd1};
        tbl[5] = '{0, 0, 1, mem_word(16'd4), 16'h0005, 16'h0005, 16'd5, 16'd1};
        tbl[6] = '{1, 1, 1, mem_word(16'd4), 16'h0005, 16'h0005, 16'd5, 16'd1};
        tbl[7] = '{0, 0, 1, mem_word(16'd5), 16'h0006, 16'h0006, 16'd6, 16'd1};

        drive(0, 0, 0, 16'h0000, 0);
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();

        for (int unsigned i = 0; i < 8; i++) begin
            step(tbl[i].pk, tbl[i].ik, 0, 16'h0000, 0);
            chk($sformatf("tbl%0d.valid", i), 16'(bus.ifidValid), 16'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.instr", i), bus.ifidInstr, tbl[i].e_instr);
            if (tbl[i].e_valid) chk($sformatf("tbl%0d.ifpc", i), bus.ifidPc, tbl[i].e_pc);
            chk($sformatf("tbl%0d.addr", i), bus.instrAddr, tbl[i].e_addr);
            chk($sformatf("tbl%0d.fcnt", i), bus.fetchCount, tbl[i].e_fc);
            chk($sformatf("tbl%0d.bcnt", i), bus.bubbleCount, tbl[i].e_bc);
        end

        // Redirect 0x0010 -> 0x0100: one bubble, then the target instruction
        step(0, 0, 1, 16'h0010, 0);
        chk_model("redir_a");
        step(0, 0, 1, 16'h0100, 0);
        chk("redir.bubble", 16'(bus.ifidValid), 16'h0000);
        chk("redir.addr", bus.instrAddr, 16'h0100);
        step(0, 0, 0, 16'h0000, 0);
        chk("redir.valid", 16'(bus.ifidValid), 16'h0001);
        chk("redir.instr", bus.ifidInstr, mem_word(16'h0100));
        chk("redir.ifpc", bus.ifidPc, 16'h0101);

        // MEM borrows instruction memory for two cycles, then redirect beats it
        bc0 = m_bc; pc0 = m_pc;
        drive(0, 0, 0, 16'h0000, 1);
        #1;
        chk("memuse.req", 16'(bus.instrReq), 16'h0000);
        step(0, 0, 0, 16'h0000, 1);
        step(0, 0, 0, 16'h0000, 1);
        chk("memuse.req2", 16'(bus.instrReq), 16'h0000);
        chk("memuse.addr", bus.instrAddr, pc0);
        chk("memuse.valid", 16'(bus.ifidValid), 16'h0000);
        chk("memuse.bcnt", bus.bubbleCount, bc0 + 16'd2);
        step(0, 0, 1, 16'h0200, 1);
        chk("memredir.addr", bus.instrAddr, 16'h0200);
        chk("memredir.valid", 16'(bus.ifidValid), 16'h0000);
        step(0, 0, 0, 16'h0000, 0);
        chk("memredir.instr", bus.ifidInstr, mem_word(16'h0200));
        chk_model("memredir");

        // PC wrap at 0xFFFF
        step(0, 0, 1, 16'hFFFF, 0);
        step(0, 0, 0, 16'h0000, 0);
        chk("wrap.ifpc", bus.ifidPc, 16'h0000);
        chk("wrap.addr", bus.instrAddr, 16'h0000);
        chk("wrap.instr", bus.ifidInstr, mem_word(16'hFFFF));

        // Asynchronous reset in the middle of a stall cycle
        step(0, 0, 0, 16'h0000, 1);
        #2;
        rst = 1'b1;
        #1;
        drive(0, 0, 0, 16'h0000, 0);
        #1;
        chk_reset_vals("areset");
        #1;
        rst = 1'b0;
        m_reset();
        step(0, 0, 0, 16'h0000, 0);
        chk("areset.boot_bcnt", bus.bubbleCount, 16'h0001);
        chk_model("after_areset");

        // Randomised mix of stalls, redirects and keeps against the model
        for (int unsigned i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, word_t'($urandom),
                 $urandom_range(0, 5) == 0);
            chk_model($sformatf("rnd%0d", i));
        end

        // Long straight-line fetch run to drive fetchCount into saturation
        for (int unsigned i = 0; i < 65600; i++)
            step(0, 0, 0, 16'h0000, 0);
        chk("sat.fcnt", bus.fetchCount, 16'hFFFF);
        step(0, 0, 0, 16'h0000, 0);
        chk("sat.fcnt_hold", bus.fetchCount, 16'hFFFF);
        chk_model("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
